shift_right_halfword_imm_pipe: RTL and testbench

- Two-stage pipelined SPU execution unit for the halfword right-shift-immediate pair.
  - ROTHMI: logical shift right halfword immediate.
  - ROTMAHI: algebraic shift right halfword immediate.
- Applied across eight independent 16-bit lanes of a 128-bit operand.
- Sits in the even pipe next to the left-shift halfword-immediate unit.
- Exchanges operands and results with issue and writeback through valid/ready handshakes, and carries the destination register tag alongside the data.

---
 rtl/shift_right_halfword_imm_pipe_if.sv | 26 ++
 rtl/shift_right_halfword_imm_pipe.sv | 111 +++++++++++
 tb/tb_shift_right_halfword_imm_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_right_halfword_imm_pipe_if.sv
// Issue/writeback bundle for the halfword right-shift-immediate unit.
// The master side is issue plus writeback; the slave side is the execution unit.
interface shift_right_halfword_imm_pipe_if #(
   parameter int TAG_W = 7
);
   logic             in_valid;
   logic             in_ready;
   logic             in_arith;
   logic [127:0]     register_RA;
   logic [6:0]       imm7;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     register_RT;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_arith, register_RA, imm7, in_tag, out_ready,
      input  in_ready, out_valid, register_RT, out_tag
   );

   modport slave (
      input  in_valid, in_arith, register_RA, imm7, in_tag, out_ready,
      output in_ready, out_valid, register_RT, out_tag
   );
endinterface

// File: rtl/shift_right_halfword_imm_pipe.sv
// Two-stage ROTHMI / ROTMAHI unit: stage 1 latches operands and the shift count,
// stage 2 latches the eight per-lane shifted halfwords.
module shift_right_halfword_imm_pipe #(
   parameter int TAG_W  = 7,
   parameter int LANE_W = 16,
   parameter int LANES  = 8
) (
   input  logic clk,
   input  logic reset_n,
   shift_right_halfword_imm_pipe_if.slave bus
);
   logic                    s1_v_q, s1_v_d;
   logic                    s1_arith_q, s1_arith_d;
   logic [4:0]              s1_sc_q, s1_sc_d;
   logic [LANES*LANE_W-1:0] s1_ra_q, s1_ra_d;
   logic [TAG_W-1:0]        s1_tag_q, s1_tag_d;

   logic                    out_valid_q, out_valid_d;
   logic [LANES*LANE_W-1:0] rt_q, rt_d;
   logic [TAG_W-1:0]        out_tag_q, out_tag_d;

   logic                    s2_adv;
   logic                    s1_adv;
   logic                    in_ready;
   logic [15:0]             imm_sext;
   logic [4:0]              sc_in;
   logic [LANES*LANE_W-1:0] lane_res;

   assign s2_adv   = !out_valid_q || bus.out_ready;
   assign s1_adv   = s2_adv;
   assign in_ready = !s1_v_q || s1_adv;

   // The immediate encodes the negated shift amount; only its low five bits matter.
   assign imm_sext = {{9{bus.imm7[6]}}, bus.imm7};
   assign sc_in    = 5'(16'd0 - imm_sext);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [LANE_W-1:0]        x;
         logic [LANE_W-1:0]        srl_res;
         logic signed [LANE_W-1:0] sra_res;

         assign x       = s1_ra_q[gi*LANE_W +: LANE_W];
         assign srl_res = x >> s1_sc_q[3:0];
         assign sra_res = $signed(x) >>> s1_sc_q[3:0];

         // Counts of 16 and above flush the lane to zero or to the sign bit.
         always_comb begin
            if (s1_sc_q[4]) begin
               lane_res[gi*LANE_W +: LANE_W] = s1_arith_q ? {LANE_W{x[LANE_W-1]}} : '0;
            end else begin
               lane_res[gi*LANE_W +: LANE_W] = s1_arith_q ? sra_res : srl_res;
            end
         end
      end
   endgenerate

   always_comb begin
      s1_v_d      = s1_v_q;
      s1_arith_d  = s1_arith_q;
      s1_sc_d     = s1_sc_q;
      s1_ra_d     = s1_ra_q;
      s1_tag_d    = s1_tag_q;
      out_valid_d = out_valid_q;
      rt_d        = rt_q;
      out_tag_d   = out_tag_q;

      if (in_ready) begin
         s1_v_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_arith_d = bus.in_arith;
            s1_sc_d    = sc_in;
            s1_ra_d    = bus.register_RA;
            s1_tag_d   = bus.in_tag;
         end
      end

      if (s2_adv) begin
         out_valid_d = s1_v_q;
         rt_d        = lane_res;
         out_tag_d   = s1_tag_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_v_q      <= 1'b0;
         s1_arith_q  <= 1'b0;
         s1_sc_q     <= '0;
         s1_ra_q     <= '0;
         s1_tag_q    <= '0;
         out_valid_q <= 1'b0;
         rt_q        <= '0;
         out_tag_q   <= '0;
      end else begin
         s1_v_q      <= s1_v_d;
         s1_arith_q  <= s1_arith_d;
         s1_sc_q     <= s1_sc_d;
         s1_ra_q     <= s1_ra_d;
         s1_tag_q    <= s1_tag_d;
         out_valid_q <= out_valid_d;
         rt_q        <= rt_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.register_RT = rt_q;
   assign bus.out_tag     = out_tag_q;
endmodule

// File: tb/tb_shift_right_halfword_imm_pipe.sv
// Directed bench for the halfword right-shift-immediate pipe: hand-computed results
// are queued at issue and compared in order as writeback accepts them.
module tb_shift_right_halfword_imm_pipe;
   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   typedef struct packed {
      logic [127:0] rt;
      logic [6:0]   tag;
   } exp_t;

   exp_t exp_q[$];

   shift_right_halfword_imm_pipe_if #(.TAG_W(7)) bus ();

   shift_right_halfword_imm_pipe #(.TAG_W(7), .LANE_W(16), .LANES(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one instruction until it handshakes; queues its expected result.
   task automatic issue(input logic arith, input logic [127:0] ra, input logic [6:0] imm,
                        input logic [6:0] tag, input logic [127:0] exp_rt, output int waits);
      bit   hs;
      exp_t e;
      hs    = 1'b0;
      waits = 0;
      bus.in_valid    = 1'b1;
      bus.in_arith    = arith;
      bus.register_RA = ra;
      bus.imm7        = imm;
      bus.in_tag      = tag;
      while (!hs && waits < 50) begin
         @(negedge clk);
         hs = bus.in_ready;
         @(posedge clk);
         #1;
         waits++;
      end
      bus.in_valid = 1'b0;
      check_eq("issue_accept", 128'(hs), 128'd1);
      if (hs) begin
         e.rt  = exp_rt;
         e.tag = tag;
         exp_q.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_eq("drain_empty", 128'(exp_q.size()), 128'd0);
   endtask

   always @(negedge clk) begin
      if (reset_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_result", 128'(bus.out_valid), 128'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("result tag=%0d rt=%h", bus.out_tag, bus.register_RT);
            check_eq("result_rt", bus.register_RT, e.rt);
            check_eq("result_tag", 128'(bus.out_tag), 128'(e.tag));
         end
      end
   end

   initial begin
      int           w;
      logic [15:0]  s_in  [6];
      logic [15:0]  s_out [6];
      logic [127:0] ra_a;
      logic [127:0] ra_b;
      logic [127:0] exp_e;

      n_checks = 0;
      n_errors = 0;
      reset_n         = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_arith    = 1'b0;
      bus.register_RA = '0;
      bus.imm7        = '0;
      bus.in_tag      = '0;
      bus.out_ready   = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 128'(bus.out_valid), 128'd0);
      check_eq("rst_rt", bus.register_RT, 128'd0);
      check_eq("rst_tag", 128'(bus.out_tag), 128'd0);
      check_eq("rst_in_ready", 128'(bus.in_ready), 128'd1);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Zero-fill and sign-fill by 4
      ra_a = 128'h8000_7FFF_1234_FFFF_0001_8001_AAAA_5555;
      issue(1'b0, ra_a, 7'h7C, 7'd21, 128'h0800_07FF_0123_0FFF_0000_0800_0AAA_0555, w);
      issue(1'b1, ra_a, 7'h7C, 7'd22, 128'hF800_07FF_0123_FFFF_0000_F800_FAAA_0555, w);
      drain();

      // Count boundaries 0, 15, 16, 31
      ra_b = {8{16'h8001}};
      issue(1'b0, ra_b, 7'h00, 7'd30, ra_b, w);
      issue(1'b1, ra_b, 7'h00, 7'd31, ra_b, w);
      issue(1'b0, ra_b, 7'h71, 7'd32, {8{16'h0001}}, w);
      issue(1'b1, ra_b, 7'h71, 7'd33, {8{16'hFFFF}}, w);
      issue(1'b0, ra_b, 7'h70, 7'd34, {8{16'h0000}}, w);
      issue(1'b1, ra_b, 7'h70, 7'd35, {8{16'hFFFF}}, w);
      issue(1'b0, ra_b, 7'h01, 7'd36, {8{16'h0000}}, w);
      issue(1'b1, ra_b, 7'h01, 7'd37, {8{16'hFFFF}}, w);
      drain();

      // Back-to-back stream, arithmetic shift by 1
      s_in[0] = 16'h0002; s_out[0] = 16'h0001;
      s_in[1] = 16'h8000; s_out[1] = 16'hC000;
      s_in[2] = 16'h1234; s_out[2] = 16'h091A;
      s_in[3] = 16'hFFFE; s_out[3] = 16'hFFFF;
      s_in[4] = 16'h7FFF; s_out[4] = 16'h3FFF;
      s_in[5] = 16'h8001; s_out[5] = 16'hC000;
      for (int i = 0; i < 6; i++) begin
         issue(1'b1, {8{s_in[i]}}, 7'h7F, 7'(i + 1), {8{s_out[i]}}, w);
         check_eq("stream_no_stall", 128'(w), 128'd1);
      end
      drain();

      // Backpressure with both stages full
      bus.out_ready = 1'b0;
      issue(1'b0, {8{16'h4000}}, 7'h7E, 7'd7, {8{16'h1000}}, w);
      issue(1'b1, {8{16'hF00F}}, 7'h7E, 7'd8, {8{16'hFC03}}, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("bp_in_ready", 128'(bus.in_ready), 128'd0);
         check_eq("bp_out_valid", 128'(bus.out_valid), 128'd1);
         check_eq("bp_rt", bus.register_RT, {8{16'h1000}});
         check_eq("bp_tag", 128'(bus.out_tag), 128'd7);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain();

      // Drain and fill in the same cycle
      bus.out_ready = 1'b0;
      issue(1'b0, {8{16'h1234}}, 7'h78, 7'd9,  {8{16'h0012}}, w);
      issue(1'b1, {8{16'hABCD}}, 7'h78, 7'd10, {8{16'hFFAB}}, w);
      bus.out_ready   = 1'b1;
      bus.in_valid    = 1'b1;
      bus.in_arith    = 1'b0;
      bus.register_RA = {8{16'h00FF}};
      bus.imm7        = 7'h78;
      bus.in_tag      = 7'd11;
      @(negedge clk);
      check_eq("df_in_ready", 128'(bus.in_ready), 128'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      exp_e = {8{16'h0000}};
      exp_q.push_back('{rt: exp_e, tag: 7'd11});
      drain();

      // Asynchronous reset with both stages valid
      bus.out_ready = 1'b0;
      issue(1'b0, {8{16'h5555}}, 7'h7F, 7'd12, {8{16'h2AAA}}, w);
      issue(1'b0, {8{16'h6666}}, 7'h7F, 7'd13, {8{16'h3333}}, w);
      #2;
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      check_eq("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
      check_eq("mid_rst_rt", bus.register_RT, 128'd0);
      check_eq("mid_rst_tag", 128'(bus.out_tag), 128'd0);
      check_eq("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("post_rst_idle", 128'(bus.out_valid), 128'd0);
      end
      check_eq("final_queue", 128'(exp_q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
